btb_2way: RTL and testbench
===========================

# btb_2way

Two-way set-associative branch target buffer for the fetch stage. Looked up combinationally with the fetch PC, in parallel with the 2-bit BHT that is indexed by the same PC bits. Fetch redirects to `o_btb_target` when `o_btb_hit` and the BHT's taken prediction are both asserted. Written by the execute stage when a taken branch or jump resolves; supports a one-cycle full invalidate for `fence.i` and flush.

## Interface

Parameters:

- `SET_COUNT`, 64: number of sets; must equal the BHT set count.
- `INDEX_WIDTH`, 6: log2(`SET_COUNT`).
- `ADDR_WIDTH`, 64: PC and target width.
- `TAG_WIDTH`, `ADDR_WIDTH - INDEX_WIDTH - 2`: stored tag width.

Ports:

- `i_clk`, in, 1: clock; all state changes on the rising edge.
- `i_arst`, in, 1: asynchronous, active-high reset.
- `i_lookup_valid`, in, 1: fetch is presenting a real PC this cycle; qualifies the LRU touch.
- `i_lookup_pc`, in, `ADDR_WIDTH`: fetch PC.
- `o_btb_hit`, out, 1: tag match on a valid way of the indexed set.
- `o_btb_target`, out, `ADDR_WIDTH`: predicted target; `{stored[ADDR_WIDTH-3:0], 2'b00}`; all zeros when there is no hit.
- `i_btb_update`, in, 1: write request from resolved taken control transfer.
- `i_update_pc`, in, `ADDR_WIDTH`: PC of the resolved branch.
- `i_update_target`, in, `ADDR_WIDTH`: resolved target; bits [1:0] are ignored.
- `i_invalidate`, in, 1: clear all entries.

## Operation

Address split, for both lookup and update PCs:

- index = pc[INDEX_WIDTH+1:2]
- tag = pc[ADDR_WIDTH-1:INDEX_WIDTH+2]
- pc[1:0] is ignored.

State, per set:

- two ways, each holding valid, tag, and target[ADDR_WIDTH-1:2];
- one `lru` bit naming the least-recently-used way.

Lookup (combinational):

- way w hits when valid[w] is set and tag[w] equals the lookup tag;
- `o_btb_hit` = hit0 | hit1;
- target is taken from way 0 if hit0, else from way 1. Both ways hitting is illegal but defined: way 0 wins.

LRU touch on lookup:

- when `i_lookup_valid` & `o_btb_hit`, `lru[index]` <= the non-hit way (way 0 wins on a double hit).

Update, when `i_btb_update` is asserted:

- if the update tag matches a valid way, rewrite that way's target. The tag is unchanged and valid stays 1.
- else allocate the victim:
  - way 0 if invalid;
  - else way 1 if invalid;
  - else the way `lru[index]` names.
- write valid=1, tag, and target into the chosen way.
- `lru[index]` <= the way not written.

Priority within one cycle:

- `i_arst` > `i_invalidate` > update > lookup LRU touch.
- Invalidate clears every valid bit and every lru bit; a simultaneous update is dropped.
- Update and lookup to the same set: only the update's LRU write happens.
- Update and lookup to different sets: both LRU writes happen.

Reset and storage:

- Reset clears all valid bits and all lru bits.
- Tag and target arrays are not reset and are never observable while invalid.

## Timing

- Lookup: zero latency; outputs are combinational from `i_lookup_pc` and the current state.
- Update: takes effect at the clock edge; visible to lookup from the next cycle.
- No write-to-read bypass: a lookup in the update cycle sees the old contents.
- Invalidate: one cycle; `o_btb_hit` = 0 for every PC from the next cycle.
- During and after reset, until the first update: `o_btb_hit` = 0 and `o_btb_target` = 0.
- Reset asserted mid-operation: state clears immediately (asynchronously). Any update in that cycle is lost.
- No stalls or backpressure; an update is accepted every cycle.

## Test plan

- **Reset and cold miss:** pulse `i_arst`, then look up 0x1000 → `o_btb_hit`=0 and `o_btb_target`=0.
- **Allocate, hit and no bypass:** update pc=0x1000 with target=0x2003 → in the same cycle a lookup of 0x1000 misses; the next cycle it hits with target 0x2000. Lookup 0x1002 also hits (low bits ignored).
- **Two-way fill and LRU eviction:**
  - update A=0x1000, then B=0x1100 (same index 0, different tag), then look up A with valid to touch it;
  - then update C=0x1200 → B is evicted;
  - A and C hit; B misses.
- **Retarget in place:** after A→0x2000, update A→0x3000 → A hits with 0x3000. The other way in the set is still valid and unchanged.
- **Invalidate precedence:** fill 3 sets, then assert `i_invalidate` together with an update of 0x4000 → the next cycle all lookups miss, including 0x4000.
- **Update/lookup same set:** with the set holding A (way 0) and B (way 1) and lru=0, look up A with valid while updating D to the same set → D replaces way 0 (the lru way at the edge) and lru becomes 1. A misses; B and D hit.

Source files
------------

// File: rtl/btb_2way.sv
// Two-way set-associative branch target buffer.
// Combinational lookup on the fetch PC, per-set LRU bit, clocked update from
// execute, and a single-cycle full invalidate.
module btb_2way #(
  parameter int unsigned SET_COUNT   = 64,
  parameter int unsigned INDEX_WIDTH = 6,
  parameter int unsigned ADDR_WIDTH  = 64,
  parameter int unsigned TAG_WIDTH   = ADDR_WIDTH - INDEX_WIDTH - 2
) (
  input  logic                  i_clk,
  input  logic                  i_arst,
  input  logic                  i_lookup_valid,
  input  logic [ADDR_WIDTH-1:0] i_lookup_pc,
  output logic                  o_btb_hit,
  output logic [ADDR_WIDTH-1:0] o_btb_target,
  input  logic                  i_btb_update,
  input  logic [ADDR_WIDTH-1:0] i_update_pc,
  input  logic [ADDR_WIDTH-1:0] i_update_target,
  input  logic                  i_invalidate
);

  localparam int unsigned TGT_WIDTH = ADDR_WIDTH - 2;

  // Valid and LRU bits are reset; tag/target storage is not.
  logic [SET_COUNT-1:0] vld0_q;
  logic [SET_COUNT-1:0] vld1_q;
  logic [SET_COUNT-1:0] lru_q;
  logic [TAG_WIDTH-1:0] tag0_q [SET_COUNT];
  logic [TAG_WIDTH-1:0] tag1_q [SET_COUNT];
  logic [TGT_WIDTH-1:0] tgt0_q [SET_COUNT];
  logic [TGT_WIDTH-1:0] tgt1_q [SET_COUNT];

  logic [INDEX_WIDTH-1:0] lk_idx;
  logic [TAG_WIDTH-1:0]   lk_tag;
  logic                   lk_hit0;
  logic                   lk_hit1;

  logic [INDEX_WIDTH-1:0] up_idx;
  logic [TAG_WIDTH-1:0]   up_tag;
  logic                   up_hit0;
  logic                   up_hit1;
  logic                   up_way;

  // PC bits [1:0] and target bits [1:0] carry no information here.
  logic unused_low_bits;
  assign unused_low_bits = ^{i_lookup_pc[1:0], i_update_pc[1:0], i_update_target[1:0]};

  assign lk_idx = i_lookup_pc[INDEX_WIDTH+1:2];
  assign lk_tag = i_lookup_pc[ADDR_WIDTH-1:INDEX_WIDTH+2];
  assign up_idx = i_update_pc[INDEX_WIDTH+1:2];
  assign up_tag = i_update_pc[ADDR_WIDTH-1:INDEX_WIDTH+2];

  // Lookup: tag compare on both ways, way 0 wins a double hit.
  always_comb begin
    lk_hit0      = vld0_q[lk_idx] && (tag0_q[lk_idx] == lk_tag);
    lk_hit1      = vld1_q[lk_idx] && (tag1_q[lk_idx] == lk_tag);
    o_btb_hit    = lk_hit0 || lk_hit1;
    o_btb_target = '0;
    if (lk_hit0) begin
      o_btb_target = {tgt0_q[lk_idx], 2'b00};
    end else if (lk_hit1) begin
      o_btb_target = {tgt1_q[lk_idx], 2'b00};
    end
  end

  // Update way choice: matching way, else first invalid way, else LRU way.
  always_comb begin
    up_hit0 = vld0_q[up_idx] && (tag0_q[up_idx] == up_tag);
    up_hit1 = vld1_q[up_idx] && (tag1_q[up_idx] == up_tag);
    if (up_hit0) begin
      up_way = 1'b0;
    end else if (up_hit1) begin
      up_way = 1'b1;
    end else if (!vld0_q[up_idx]) begin
      up_way = 1'b0;
    end else if (!vld1_q[up_idx]) begin
      up_way = 1'b1;
    end else begin
      up_way = lru_q[up_idx];
    end
  end

  // Valid/LRU state: reset and invalidate clear everything, update beats lookup touch.
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      vld0_q <= '0;
      vld1_q <= '0;
      lru_q  <= '0;
    end else if (i_invalidate) begin
      vld0_q <= '0;
      vld1_q <= '0;
      lru_q  <= '0;
    end else begin
      // On a hit, LRU points at the other way; lk_hit0 is exactly that way number.
      if (i_lookup_valid && o_btb_hit && !(i_btb_update && (up_idx == lk_idx))) begin
        lru_q[lk_idx] <= lk_hit0;
      end
      if (i_btb_update) begin
        if (up_way) begin
          vld1_q[up_idx] <= 1'b1;
        end else begin
          vld0_q[up_idx] <= 1'b1;
        end
        lru_q[up_idx] <= ~up_way;
      end
    end
  end

  // Tag/target storage write for the chosen way.
  always_ff @(posedge i_clk) begin
    if (i_btb_update && !i_invalidate) begin
      if (up_way) begin
        tag1_q[up_idx] <= up_tag;
        tgt1_q[up_idx] <= i_update_target[ADDR_WIDTH-1:2];
      end else begin
        tag0_q[up_idx] <= up_tag;
        tgt0_q[up_idx] <= i_update_target[ADDR_WIDTH-1:2];
      end
    end
  end

endmodule

// File: tb/tb_btb_2way.sv
// Self-checking bench for btb_2way: directed scenarios followed by random
// traffic, compared against a per-set behavioural model.
module tb_btb_2way;

  logic        i_clk;
  logic        i_arst;
  logic        i_lookup_valid;
  logic [63:0] i_lookup_pc;
  logic        o_btb_hit;
  logic [63:0] o_btb_target;
  logic        i_btb_update;
  logic [63:0] i_update_pc;
  logic [63:0] i_update_target;
  logic        i_invalidate;

  int checks;
  int failures;

  // Model: each set has two slots and a record of which slot was used least recently.
  bit          mv   [64][2];
  logic [63:0] mtag [64][2];
  logic [63:0] mtgt [64][2];
  int          mlru [64];

  btb_2way #(
    .SET_COUNT  (64),
    .INDEX_WIDTH(6),
    .ADDR_WIDTH (64)
  ) dut (
    .i_clk          (i_clk),
    .i_arst         (i_arst),
    .i_lookup_valid (i_lookup_valid),
    .i_lookup_pc    (i_lookup_pc),
    .o_btb_hit      (o_btb_hit),
    .o_btb_target   (o_btb_target),
    .i_btb_update   (i_btb_update),
    .i_update_pc    (i_update_pc),
    .i_update_target(i_update_target),
    .i_invalidate   (i_invalidate)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  function automatic int set_of(input logic [63:0] pc);
    return int'((pc >> 2) % 64);
  endfunction

  function automatic void mdl_clear();
    for (int s = 0; s < 64; s++) begin
      mv[s][0] = 1'b0;
      mv[s][1] = 1'b0;
      mlru[s]  = 0;
    end
  endfunction

  function automatic void mdl_look(input logic [63:0] pc, output bit hit, output int way,
                                   output logic [63:0] tgt);
    int s;
    s   = set_of(pc);
    hit = 1'b0;
    way = 0;
    tgt = 64'd0;
    for (int w = 1; w >= 0; w--) begin
      if (mv[s][w] && mtag[s][w] == (pc >> 8)) begin
        hit = 1'b1;
        way = w;
        tgt = mtgt[s][w] & ~64'h3;
      end
    end
  endfunction

  function automatic void mdl_edge(input bit lv, input logic [63:0] lpc, input bit upd,
                                   input logic [63:0] upc, input logic [63:0] utgt, input bit inv);
    bit h;
    int w;
    logic [63:0] t;
    int ls;
    int us;
    if (inv) begin
      mdl_clear();
      return;
    end
    ls = set_of(lpc);
    us = set_of(upc);
    mdl_look(lpc, h, w, t);
    if (lv && h && !(upd && ls == us)) mlru[ls] = 1 - w;
    if (upd) begin
      mdl_look(upc, h, w, t);
      if (!h) begin
        if (!mv[us][0]) w = 0;
        else if (!mv[us][1]) w = 1;
        else w = mlru[us];
      end
      mv[us][w]   = 1'b1;
      mtag[us][w] = upc >> 8;
      mtgt[us][w] = utgt;
      mlru[us]    = 1 - w;
    end
  endfunction

  task automatic idle();
    i_lookup_valid  = 1'b0;
    i_btb_update    = 1'b0;
    i_invalidate    = 1'b0;
    i_update_pc     = '0;
    i_update_target = '0;
  endtask

  // One clock cycle: drive at negedge, check same-cycle lookup, advance model at posedge.
  task automatic step(input bit lv, input logic [63:0] lpc, input bit upd,
                      input logic [63:0] upc, input logic [63:0] utgt, input bit inv);
    bit h;
    int w;
    logic [63:0] t;
    @(negedge i_clk);
    i_lookup_valid  = lv;
    i_lookup_pc     = lpc;
    i_btb_update    = upd;
    i_update_pc     = upc;
    i_update_target = utgt;
    i_invalidate    = inv;
    #1;
    mdl_look(lpc, h, w, t);
    check("step_hit", {63'd0, o_btb_hit}, {63'd0, h});
    check("step_target", o_btb_target, t);
    @(posedge i_clk);
    mdl_edge(lv, lpc, upd, upc, utgt, inv);
    #1;
    idle();
  endtask

  // Combinational probe with no state change; checks against fixed expectations.
  task automatic probe(input string name, input logic [63:0] pc, input bit exp_hit,
                       input logic [63:0] exp_tgt);
    idle();
    i_lookup_pc = pc;
    #1;
    check({name, "_hit"}, {63'd0, o_btb_hit}, {63'd0, exp_hit});
    check({name, "_target"}, o_btb_target, exp_tgt);
  endtask

  task automatic pulse_reset();
    @(negedge i_clk);
    idle();
    i_arst = 1'b1;
    #1;
    check("reset_hit", {63'd0, o_btb_hit}, 64'd0);
    @(negedge i_clk);
    i_arst = 1'b0;
    mdl_clear();
  endtask

  function automatic logic [63:0] rand_pc();
    logic [63:0] tg;
    logic [63:0] ix;
    tg = 64'($urandom_range(0, 4));
    if (tg == 64'd4) tg = 64'h00FF_FFFF_FFFF_FFFF;
    ix = 64'($urandom_range(0, 3));
    return (tg << 8) | (ix << 2) | 64'($urandom_range(0, 3));
  endfunction

  localparam logic [63:0] PA = 64'h1000;
  localparam logic [63:0] PB = 64'h1100;
  localparam logic [63:0] PC = 64'h1200;
  localparam logic [63:0] PD = 64'h1300;
  localparam logic [63:0] PE = 64'h1400;

  initial begin
    checks   = 0;
    failures = 0;
    idle();
    i_lookup_pc = PA;
    i_arst      = 1'b1;
    mdl_clear();

    // Reset and cold miss
    #3;
    check("in_reset_hit", {63'd0, o_btb_hit}, 64'd0);
    check("in_reset_target", o_btb_target, 64'd0);
    @(negedge i_clk);
    i_arst = 1'b0;
    probe("cold", PA, 1'b0, 64'd0);

    // Allocate, no bypass, hit with low bits ignored
    step(1'b1, PA, 1'b1, PA, 64'h2003, 1'b0);
    probe("alloc", PA, 1'b1, 64'h2000);
    probe("alloc_lowbits", 64'h1002, 1'b1, 64'h2000);

    // Two-way fill and LRU eviction
    pulse_reset();
    step(1'b0, 64'd0, 1'b1, PA, 64'h2000, 1'b0);
    step(1'b0, 64'd0, 1'b1, PB, 64'h2100, 1'b0);
    step(1'b1, PA, 1'b0, 64'd0, 64'd0, 1'b0);
    step(1'b0, 64'd0, 1'b1, PC, 64'h2200, 1'b0);
    probe("evict_a", PA, 1'b1, 64'h2000);
    probe("evict_c", PC, 1'b1, 64'h2200);
    probe("evict_b", PB, 1'b0, 64'd0);

    // Retarget in place
    step(1'b0, 64'd0, 1'b1, PA, 64'h3000, 1'b0);
    probe("retarget_a", PA, 1'b1, 64'h3000);
    probe("retarget_c", PC, 1'b1, 64'h2200);

    // Invalidate beats a simultaneous update
    step(1'b0, 64'd0, 1'b1, 64'h1044, 64'h2444, 1'b0);
    step(1'b0, 64'd0, 1'b1, 64'h1088, 64'h2888, 1'b0);
    step(1'b0, 64'd0, 1'b1, 64'h4000, 64'h5000, 1'b1);
    probe("inv_a", PA, 1'b0, 64'd0);
    probe("inv_44", 64'h1044, 1'b0, 64'd0);
    probe("inv_88", 64'h1088, 1'b0, 64'd0);
    probe("inv_upd", 64'h4000, 1'b0, 64'd0);

    // Update and lookup touch to the same set: update's LRU write wins
    pulse_reset();
    step(1'b0, 64'd0, 1'b1, PA, 64'h2000, 1'b0);
    step(1'b0, 64'd0, 1'b1, PB, 64'h2100, 1'b0);
    step(1'b1, PA, 1'b1, PD, 64'h2300, 1'b0);
    probe("same_a", PA, 1'b0, 64'd0);
    probe("same_b", PB, 1'b1, 64'h2100);
    probe("same_d", PD, 1'b1, 64'h2300);
    step(1'b0, 64'd0, 1'b1, PE, 64'h2400, 1'b0);
    probe("same_lru_b", PB, 1'b0, 64'd0);
    probe("same_lru_d", PD, 1'b1, 64'h2300);

    // Asynchronous reset in the middle of an update cycle
    step(1'b0, 64'd0, 1'b1, PA, 64'h2000, 1'b0);
    @(negedge i_clk);
    i_lookup_pc     = PA;
    i_btb_update    = 1'b1;
    i_update_pc     = 64'h1044;
    i_update_target = 64'h2444;
    #1;
    check("pre_arst_hit", {63'd0, o_btb_hit}, 64'd1);
    i_arst = 1'b1;
    #1;
    check("arst_async_hit", {63'd0, o_btb_hit}, 64'd0);
    check("arst_async_target", o_btb_target, 64'd0);
    @(negedge i_clk);
    i_arst = 1'b0;
    mdl_clear();
    probe("arst_lost_upd", 64'h1044, 1'b0, 64'd0);

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      step(1'($urandom_range(0, 1)), rand_pc(), 1'($urandom_range(0, 1)), rand_pc(),
           {$urandom, $urandom}, ($urandom_range(0, 31) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
